// File: rtl/aemb2_wbmx.sv
// Writeback stage for the AEMB2 pipeline: carries OF destination/source info to MX,
// aligns multiplier and load data with ALU results, and flags read-after-multiply hazards.
module aemb2_wbmx #(
    parameter int AEMB_MUL = 1
) (
    input  logic        gclk,
    input  logic        grst,
    input  logic        dena,
    input  logic        gpha,
    input  logic [5:0]  opc_of,
    input  logic [4:0]  rd_of,
    input  logic        wre_of,
    input  logic [4:0]  ra_of,
    input  logic [4:0]  rb_of,
    input  logic [31:0] alu_ma,
    input  logic [31:0] mul_mx,
    input  logic [31:0] dwb_dat_i,
    input  logic [3:0]  dwb_sel_ma,
    output logic [4:0]  rd_mx,
    output logic        wre_mx,
    output logic [31:0] dat_mx,
    output logic        pha_mx,
    output logic        hzd_mul
);

    typedef enum logic [1:0] {
        SRC_ALU = 2'd0,
        SRC_MUL = 2'd1,
        SRC_LD  = 2'd2
    } src_t;

    src_t        src_of;
    src_t        src_ma_reg, src_mx_reg;
    logic [4:0]  rd_ma_reg, rd_mx_reg;
    logic        wre_ma_reg, wre_mx_reg;
    logic        pha_ma_reg, pha_mx_reg;
    logic [1:0]  siz_ma_reg, siz_mx_reg;
    logic [31:0] alu_mx_reg;
    logic [3:0]  sel_mx_reg;

    always_comb begin
        src_of = SRC_ALU;
        if (opc_of == 6'h10 || opc_of == 6'h18)
            src_of = SRC_MUL;
        else if (opc_of[5:4] == 2'b11 && !opc_of[2])
            src_of = SRC_LD;
    end

    always_ff @(posedge gclk) begin
        if (grst) begin
            src_ma_reg <= SRC_ALU;
            rd_ma_reg  <= 5'd0;
            wre_ma_reg <= 1'b0;
            pha_ma_reg <= 1'b0;
            siz_ma_reg <= 2'd0;
            src_mx_reg <= SRC_ALU;
            rd_mx_reg  <= 5'd0;
            wre_mx_reg <= 1'b0;
            pha_mx_reg <= 1'b0;
            siz_mx_reg <= 2'd0;
            alu_mx_reg <= 32'd0;
            sel_mx_reg <= 4'd0;
        end else if (dena) begin
            src_ma_reg <= src_of;
            rd_ma_reg  <= rd_of;
            wre_ma_reg <= wre_of;
            pha_ma_reg <= gpha;
            siz_ma_reg <= opc_of[1:0];
            src_mx_reg <= src_ma_reg;
            rd_mx_reg  <= rd_ma_reg;
            wre_mx_reg <= wre_ma_reg;
            pha_mx_reg <= pha_ma_reg;
            siz_mx_reg <= siz_ma_reg;
            alu_mx_reg <= alu_ma;
            sel_mx_reg <= dwb_sel_ma;
        end
    end

    // Byte lanes of the read data, lane 3 being the most significant (big-endian bus).
    logic [7:0] lane_byte [4];
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_byte[gi] = dwb_dat_i[8*gi +: 8];
        end
    endgenerate

    logic [31:0] ld_dat;
    always_comb begin
        ld_dat = 32'h0;
        case (siz_mx_reg)
            2'b10: ld_dat = dwb_dat_i;
            2'b01: begin
                case (sel_mx_reg)
                    4'b1100: ld_dat = {16'h0, lane_byte[3], lane_byte[2]};
                    4'b0011: ld_dat = {16'h0, lane_byte[1], lane_byte[0]};
                    default: ld_dat = 32'h0;
                endcase
            end
            2'b00: begin
                case (sel_mx_reg)
                    4'b1000: ld_dat = {24'h0, lane_byte[3]};
                    4'b0100: ld_dat = {24'h0, lane_byte[2]};
                    4'b0010: ld_dat = {24'h0, lane_byte[1]};
                    4'b0001: ld_dat = {24'h0, lane_byte[0]};
                    default: ld_dat = 32'h0;
                endcase
            end
            default: ld_dat = 32'h0;
        endcase
    end

    always_comb begin
        dat_mx = alu_mx_reg;
        case (src_mx_reg)
            SRC_MUL: dat_mx = (AEMB_MUL != 0) ? mul_mx : 32'h0;
            SRC_LD:  dat_mx = ld_dat;
            default: dat_mx = alu_mx_reg;
        endcase
    end

    assign rd_mx  = rd_mx_reg;
    assign wre_mx = wre_mx_reg && (rd_mx_reg != 5'd0);
    assign pha_mx = pha_mx_reg;

    // A MUL result is only forwardable once it reaches MX, so a same-thread reader right behind it must wait.
    generate
        if (AEMB_MUL != 0) begin : g_hzd
            assign hzd_mul = (src_ma_reg == SRC_MUL) && wre_ma_reg && (rd_ma_reg != 5'd0) &&
                             (pha_ma_reg == gpha) &&
                             ((ra_of == rd_ma_reg) || (rb_of == rd_ma_reg));
        end else begin : g_no_hzd
            assign hzd_mul = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_aemb2_wbmx.sv
// Self-checking bench for aemb2_wbmx: directed cases then randomized traffic,
// all checked against a queue-based reference of instructions in flight.
module tb_aemb2_wbmx;

    logic        gclk = 1'b0;
    logic        grst, dena, gpha, wre_of;
    logic [5:0]  opc_of;
    logic [4:0]  rd_of, ra_of, rb_of;
    logic [31:0] alu_ma, mul_mx, dwb_dat_i;
    logic [3:0]  dwb_sel_ma;
    logic [4:0]  rd_mx;
    logic        wre_mx, pha_mx, hzd_mul;
    logic [31:0] dat_mx;

    int vectors = 0;
    int miscompares = 0;

    always #5 gclk = ~gclk;

    aemb2_wbmx #(.AEMB_MUL(1)) dut (
        .gclk(gclk), .grst(grst), .dena(dena), .gpha(gpha),
        .opc_of(opc_of), .rd_of(rd_of), .wre_of(wre_of),
        .ra_of(ra_of), .rb_of(rb_of), .alu_ma(alu_ma), .mul_mx(mul_mx),
        .dwb_dat_i(dwb_dat_i), .dwb_sel_ma(dwb_sel_ma),
        .rd_mx(rd_mx), .wre_mx(wre_mx), .dat_mx(dat_mx),
        .pha_mx(pha_mx), .hzd_mul(hzd_mul)
    );

    // One record per instruction; alu/sel are filled in while it sits in MA.
    typedef struct {
        logic [5:0]  opc;
        logic [4:0]  rd;
        logic        wre;
        logic        pha;
        logic [31:0] alu;
        logic [3:0]  sel;
    } rec_t;

    rec_t q[$];

    function automatic rec_t bubble();
        rec_t r;
        r.opc = 6'h00; r.rd = 5'd0; r.wre = 1'b0; r.pha = 1'b0; r.alu = 32'h0; r.sel = 4'h0;
        return r;
    endfunction

    function automatic bit is_mul(input logic [5:0] opc);
        return (opc == 6'h10) || (opc == 6'h18);
    endfunction

    function automatic bit is_ld(input logic [5:0] opc);
        return (opc[5:4] == 2'b11) && (opc[2] == 1'b0);
    endfunction

    function automatic logic [31:0] exp_dat(input rec_t m, input logic [31:0] mul, input logic [31:0] d);
        logic [1:0] size;
        if (is_mul(m.opc)) return mul;
        if (!is_ld(m.opc)) return m.alu;
        size = m.opc[1:0];
        if (size == 2'd2) return d;
        if (size == 2'd1) begin
            if (m.sel == 4'b1100) return d >> 16;
            if (m.sel == 4'b0011) return d & 32'h0000_FFFF;
            return 32'h0;
        end
        if (size == 2'd0) begin
            for (int lane = 0; lane < 4; lane++)
                if (m.sel == (4'b1000 >> lane)) return (d >> (24 - 8 * lane)) & 32'h0000_00FF;
            return 32'h0;
        end
        return 32'h0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        q.delete();
        q.push_back(bubble());
        q.push_back(bubble());
    endtask

    task automatic model_step();
        rec_t r, junk;
        q[q.size()-1].alu = alu_ma;
        q[q.size()-1].sel = dwb_sel_ma;
        r.opc = opc_of; r.rd = rd_of; r.wre = wre_of; r.pha = gpha; r.alu = 32'h0; r.sel = 4'h0;
        q.push_back(r);
        if (q.size() > 3) junk = q.pop_front();
    endtask

    task automatic settle();
        rec_t m, a;
        logic hz;
        #1;
        m = q[q.size()-2];
        a = q[q.size()-1];
        hz = is_mul(a.opc) && a.wre && (a.rd != 5'd0) && (a.pha == gpha) &&
             ((ra_of == a.rd) || (rb_of == a.rd));
        chk("rd_mx",   {27'h0, rd_mx},  {27'h0, m.rd});
        chk("wre_mx",  {31'h0, wre_mx}, {31'h0, (m.wre && (m.rd != 5'd0))});
        chk("pha_mx",  {31'h0, pha_mx}, {31'h0, m.pha});
        chk("dat_mx",  dat_mx, exp_dat(m, mul_mx, dwb_dat_i));
        chk("hzd_mul", {31'h0, hzd_mul}, {31'h0, hz});
    endtask

    task automatic advance();
        @(posedge gclk);
        if (grst) model_reset();
        else if (dena) model_step();
        @(negedge gclk);
        $display("t=%0t grst=%b dena=%b of:opc=%h rd=%0d wre=%b | mx:rd=%0d wre=%b dat=%h pha=%b hzd=%b",
                 $time, grst, dena, opc_of, rd_of, wre_of, rd_mx, wre_mx, dat_mx, pha_mx, hzd_mul);
    endtask

    task automatic idle();
        grst = 1'b0; dena = 1'b1; gpha = 1'b0; wre_of = 1'b0;
        opc_of = 6'h00; rd_of = 5'd0; ra_of = 5'd0; rb_of = 5'd0;
        alu_ma = 32'h0; mul_mx = 32'h0; dwb_dat_i = 32'h0; dwb_sel_ma = 4'h0;
    endtask

    task automatic run_ld(input logic [5:0] opc, input logic [4:0] rd, input logic [3:0] sel,
                          input logic [31:0] d, input logic [31:0] want);
        idle(); opc_of = opc; rd_of = rd; wre_of = 1'b1; settle(); advance();
        idle(); dwb_sel_ma = sel; settle(); advance();
        idle(); dwb_dat_i = d; settle();
        chk("ld_dat", dat_mx, want);
        chk("ld_wre", {31'h0, wre_mx}, 32'h1);
        advance();
    endtask

    logic [3:0] legal_sel [7];

    initial begin
        legal_sel[0] = 4'b1000; legal_sel[1] = 4'b0100; legal_sel[2] = 4'b0010;
        legal_sel[3] = 4'b0001; legal_sel[4] = 4'b1100; legal_sel[5] = 4'b0011;
        legal_sel[6] = 4'b1111;

        idle();
        grst = 1'b1;
        repeat (2) @(posedge gclk);
        model_reset();
        @(negedge gclk);
        grst = 1'b0;

        // Reset state
        settle();
        chk("rst_rd",  {27'h0, rd_mx}, 32'h0);
        chk("rst_wre", {31'h0, wre_mx}, 32'h0);
        chk("rst_dat", dat_mx, 32'h0);
        chk("rst_pha", {31'h0, pha_mx}, 32'h0);
        chk("rst_hzd", {31'h0, hzd_mul}, 32'h0);

        // MUL alignment: result appears two dena steps after OF
        idle(); opc_of = 6'h10; rd_of = 5'd3; wre_of = 1'b1; settle(); advance();
        idle(); settle();
        chk("mul_step1_wre", {31'h0, wre_mx}, 32'h0);
        advance();
        idle(); mul_mx = 32'h0000_0C00; settle();
        chk("mul_rd",  {27'h0, rd_mx}, 32'd3);
        chk("mul_wre", {31'h0, wre_mx}, 32'h1);
        chk("mul_dat", dat_mx, 32'h0000_0C00);
        advance();

        // Loads
        run_ld(6'h30, 5'd5, 4'b0010, 32'h1122_3344, 32'h0000_0033);
        run_ld(6'h31, 5'd6, 4'b1100, 32'hAABB_CCDD, 32'h0000_AABB);
        run_ld(6'h3A, 5'd8, 4'b1111, 32'hAABB_CCDD, 32'hAABB_CCDD);
        run_ld(6'h30, 5'd10, 4'b0110, 32'hAABB_CCDD, 32'h0000_0000);

        // Hazard
        idle(); opc_of = 6'h10; rd_of = 5'd7; wre_of = 1'b1; gpha = 1'b0; settle(); advance();
        idle(); ra_of = 5'd7; gpha = 1'b0; settle();
        chk("hzd_same_pha", {31'h0, hzd_mul}, 32'h1);
        gpha = 1'b1; settle();
        chk("hzd_other_pha", {31'h0, hzd_mul}, 32'h0);
        gpha = 1'b0; ra_of = 5'd0; rb_of = 5'd7; settle();
        chk("hzd_rb", {31'h0, hzd_mul}, 32'h1);
        advance();
        idle(); opc_of = 6'h18; rd_of = 5'd0; wre_of = 1'b1; settle(); advance();
        idle(); ra_of = 5'd0; settle();
        chk("hzd_r0", {31'h0, hzd_mul}, 32'h0);
        advance();

        // r0 never written
        idle(); opc_of = 6'h00; rd_of = 5'd0; wre_of = 1'b1; settle(); advance();
        idle(); alu_ma = 32'hFFFF_FFFF; settle(); advance();
        idle(); settle();
        chk("r0_wre", {31'h0, wre_mx}, 32'h0);
        advance();

        // Hold with dena low
        idle(); opc_of = 6'h04; rd_of = 5'd9; wre_of = 1'b1; settle(); advance();
        idle(); alu_ma = 32'h1234_5678; settle(); advance();
        for (int i = 0; i < 3; i++) begin
            idle(); dena = 1'b0;
            opc_of = 6'($urandom); rd_of = 5'($urandom); wre_of = 1'b1;
            alu_ma = $urandom; dwb_sel_ma = 4'($urandom);
            settle(); advance();
        end
        idle(); dena = 1'b0; settle();
        chk("hold_rd",  {27'h0, rd_mx}, 32'd9);
        chk("hold_wre", {31'h0, wre_mx}, 32'h1);
        chk("hold_dat", dat_mx, 32'h1234_5678);
        advance();

        // Reset mid-pipeline
        idle(); opc_of = 6'h10; rd_of = 5'd4; wre_of = 1'b1; settle(); advance();
        idle(); ra_of = 5'd4; grst = 1'b1; settle(); advance();
        idle(); ra_of = 5'd4; settle();
        chk("rst_mid_wre", {31'h0, wre_mx}, 32'h0);
        chk("rst_mid_dat", dat_mx, 32'h0);
        chk("rst_mid_hzd", {31'h0, hzd_mul}, 32'h0);
        advance();
        idle(); mul_mx = 32'hDEAD_BEEF; settle();
        chk("rst_no_stale", {31'h0, wre_mx}, 32'h0);
        advance();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            idle();
            dena = ($urandom_range(0, 9) < 8);
            grst = ($urandom_range(0, 99) < 3);
            gpha = 1'($urandom);
            case ($urandom_range(0, 3))
                0: opc_of = $urandom_range(0, 1) ? 6'h18 : 6'h10;
                1: opc_of = {2'b11, 1'($urandom), 1'b0, 2'($urandom)};
                2: opc_of = 6'($urandom);
                default: opc_of = 6'($urandom_range(0, 15));
            endcase
            rd_of = 5'($urandom_range(0, 7));
            ra_of = 5'($urandom_range(0, 7));
            rb_of = 5'($urandom_range(0, 7));
            wre_of = ($urandom_range(0, 3) != 0);
            alu_ma = $urandom;
            mul_mx = $urandom;
            dwb_dat_i = $urandom;
            dwb_sel_ma = ($urandom_range(0, 9) < 7) ? legal_sel[$urandom_range(0, 6)] : 4'($urandom);
            settle();
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
